// File: rtl/io_pkg.sv
// Shared types and constants for the processor I/O handshake responder.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } io_state_t;

  localparam int ARM_SAMPLES = 2;

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, saturating debounce counter
// and a one-cycle pulse on each accepted press.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic clock,
  input  logic rst,
  input  logic key,
  output logic pressed,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // The synchroniser clears to the board's "released" level so reset never looks like a press.
  localparam logic SYNC_IDLE = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic          sync1;
  logic          sync2;
  logic          raw;
  logic          pressed_q;
  logic [CW-1:0] cnt;

  assign raw = KEY_ACTIVE_LOW ? ~sync2 : sync2;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      sync1     <= SYNC_IDLE;
      sync2     <= SYNC_IDLE;
      cnt       <= '0;
      pressed   <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      sync1     <= key;
      sync2     <= sync1;
      pressed_q <= pressed;
      // Any sample agreeing with the accepted level restarts the count.
      if (raw != pressed) begin
        if (cnt == CNT_LAST) begin
          pressed <= raw;
          cnt     <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = pressed & ~pressed_q;

endmodule

// File: rtl/io_responder.sv
// Board-side responder for the processor ready/waiting I/O handshake:
// arms on a sustained waiting, completes the transfer on a key press (or auto delay).
module io_responder
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit KEY_ACTIVE_LOW  = 1'b1,
  parameter bit AUTO_ACK        = 1'b0,
  parameter int AUTO_DELAY      = 3
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       waiting,
  input  logic [7:0] datout,
  input  logic [7:0] sw,
  input  logic       key,
  output logic       ready,
  output logic [7:0] datin,
  output logic [7:0] led,
  output logic       pending
);

  localparam int ARM_W = $clog2(ARM_SAMPLES + 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_SAMPLES - 1);
  localparam int AUTO_W = $clog2(AUTO_DELAY + 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_DELAY - 1);

  // Handshake: the processor raises waiting and holds it; ready answers and is
  // held until waiting is seen low, after which ready stays low for >= 1 cycle.

  io_state_t         state;
  io_state_t         state_next;
  logic [ARM_W-1:0]  arm_cnt;
  logic [AUTO_W-1:0] auto_cnt;
  logic              arm_done;
  logic              auto_done;
  logic              key_level;
  logic              key_press;
  logic              ack_evt;
  logic              load_en;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
  ) u_key (
    .clock   (clock),
    .rst     (rst),
    .key     (key),
    .pressed (key_level),
    .press   (key_press)
  );

  assign arm_done  = (arm_cnt == ARM_LAST);
  assign auto_done = (auto_cnt == AUTO_LAST);
  assign ack_evt   = AUTO_ACK ? auto_done : (key_press & key_level);

  always_comb begin
    state_next = state;
    load_en    = 1'b0;
    case (state)
      IDLE:    if (waiting && arm_done) state_next = ARMED;
      ARMED: begin
        // A waiting drop wins over a simultaneous acknowledge.
        if (!waiting) begin
          state_next = IDLE;
        end else if (ack_evt) begin
          state_next = ACK;
          load_en    = 1'b1;
        end
      end
      ACK:     if (!waiting) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      arm_cnt  <= '0;
      auto_cnt <= '0;
      datin    <= 8'h00;
      led      <= 8'h00;
    end else begin
      state    <= state_next;
      // Only samples taken while idle count towards arming.
      arm_cnt  <= (state == IDLE && waiting && !arm_done) ? arm_cnt + ARM_W'(1) : '0;
      auto_cnt <= (state == ARMED && !auto_done) ? auto_cnt + AUTO_W'(1) : '0;
      if (load_en) begin
        datin <= sw;
        led   <= datout;
      end
    end
  end

  assign ready   = (state == ACK);
  assign pending = (state == ARMED);

endmodule
